// File: rtl/ten_bit_loop_counter_if.sv
// Handshake/bus bundle for the 10-bit loop counter sequencer.
// master = CPU-side driver, slave = the counter itself.
interface ten_bit_loop_counter_if;
  logic       load;
  logic [9:0] load_value;
  logic       start;
  logic       step;
  logic       abort;
  logic [9:0] count;
  logic       zero;
  logic       busy;
  logic       done;

  modport master (
    output load, load_value, start, step, abort,
    input  count, zero, busy, done
  );

  modport slave (
    input  load, load_value, start, step, abort,
    output count, zero, busy, done
  );
endinterface

// File: rtl/ten_bit_loop_counter.sv
// Loadable 10-bit down-counter sequencer with start/busy/done handshake.
// Optional macro LOOP_COUNTER_AUTO_RELOAD_EN: on reaching zero, reload and keep running.
module ten_bit_decrementer (
  input  logic [9:0] i_a,
  output logic [9:0] o_y,
  output logic       o_borrow
);
  assign o_y      = i_a - 10'd1;
  assign o_borrow = (i_a == 10'd0);
endmodule

module ten_bit_loop_counter (
  input  logic                    clk,
  input  logic                    rst_n,
  ten_bit_loop_counter_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] r_state;
  logic [9:0] r_count;
  logic [9:0] r_reload;
  logic       r_busy;
  logic       r_done;

  logic [1:0] w_state_nxt;
  logic [9:0] w_count_nxt;
  logic [9:0] w_reload_nxt;
  logic       w_done_nxt;
  logic [9:0] w_dec;
  logic       w_unused_borrow;

  ten_bit_decrementer u_dec (
    .i_a      (r_count),
    .o_y      (w_dec),
    .o_borrow (w_unused_borrow)
  );

  // Next-state, next-count and completion-pulse decode
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load) begin
          w_count_nxt  = bus.load_value;
          w_reload_nxt = bus.load_value;
        end else if (bus.start) begin
          if (r_count != 10'd0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (bus.step && (r_count == 10'd1)) begin
`ifdef LOOP_COUNTER_AUTO_RELOAD_EN
          w_count_nxt = r_reload;
          w_done_nxt  = 1'b1;
`else
          w_count_nxt = w_dec;
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
`endif
        end else if (bus.step && (r_count != 10'd0)) begin
          // Zero guard keeps the counter from ever wrapping below zero
          w_count_nxt = w_dec;
        end else begin
          w_count_nxt = r_count;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, count, reload and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= 10'd0;
      r_reload <= 10'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_busy   <= (w_state_nxt == S_RUN);
      r_done   <= w_done_nxt;
    end
  end

  assign bus.count = r_count;
  assign bus.zero  = (r_count == 10'd0);
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_ten_bit_loop_counter.sv
// Directed bench for ten_bit_loop_counter with a cycle-level reference model
// and hand-computed checkpoints.
module tb_ten_bit_loop_counter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ten_bit_loop_counter_if bus ();

  ten_bit_loop_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phases 0 = waiting, 1 = counting, 2 = finishing.
  int m_phase;
  int m_count;
  int m_reload;
  int m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_count  <= 0;
      m_reload <= 0;
      m_done   <= 0;
    end else begin
      m_done <= 0;
      if (m_phase == 0) begin
        if (bus.load) begin
          m_count  <= int'(bus.load_value);
          m_reload <= int'(bus.load_value);
        end else if (bus.start) begin
          m_phase <= (m_count == 0) ? 2 : 1;
          m_done  <= (m_count == 0) ? 1 : 0;
        end
      end else if (m_phase == 1) begin
        if (bus.abort) begin
          m_phase <= 0;
        end else if (bus.step && m_count > 0) begin
          if (m_count == 1) begin
            m_done <= 1;
`ifdef LOOP_COUNTER_AUTO_RELOAD_EN
            m_count <= m_reload;
`else
            m_count <= 0;
            m_phase <= 2;
`endif
          end else begin
            m_count <= m_count - 1;
          end
        end
      end else begin
        m_phase <= 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_count", int'(bus.count), m_count);
      chk("model_zero",  int'(bus.zero),  (m_count == 0) ? 1 : 0);
      chk("model_busy",  int'(bus.busy),  (m_phase == 1) ? 1 : 0);
      chk("model_done",  int'(bus.done),  m_done);
    end
  end

  task automatic drive(input logic ld, input int lv, input logic st,
                       input logic sp, input logic ab);
    bus.load       = ld;
    bus.load_value = 10'(lv);
    bus.start      = st;
    bus.step       = sp;
    bus.abort      = ab;
    @(negedge clk);
  endtask

  task automatic pin(input string name, input int c, input int b, input int d);
    chk({name, "_count"}, int'(bus.count), c);
    chk({name, "_busy"},  int'(bus.busy),  b);
    chk({name, "_done"},  int'(bus.done),  d);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.load = 1'b0; bus.load_value = 10'd0;
    bus.start = 1'b0; bus.step = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pin("reset", 0, 0, 0);
    chk("reset_zero", int'(bus.zero), 1);
    #2 rst_n = 1'b1;
    @(negedge clk);

`ifdef LOOP_COUNTER_AUTO_RELOAD_EN
    drive(1'b1, 2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    pin("ar_e0", 2, 1, 0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("ar_e1", 1, 1, 0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("ar_e2", 2, 1, 1);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("ar_e3", 1, 1, 0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("ar_e4", 2, 1, 1);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    pin("ar_abort", 2, 0, 0);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
`else
    // Basic count: load 3, step held high
    drive(1'b1, 3, 1'b0, 1'b0, 1'b0);
    pin("basic_load", 3, 0, 0);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    pin("basic_e0", 3, 1, 0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("basic_e1", 2, 1, 0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("basic_e2", 1, 1, 0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("basic_e3", 0, 0, 1);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    pin("basic_e4", 0, 0, 0);

    // Gated steps 1,0,1
    drive(1'b1, 2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    pin("gated_e0", 2, 1, 0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("gated_e1", 1, 1, 0);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    pin("gated_e2", 1, 1, 0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("gated_e3", 0, 0, 1);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    pin("gated_e4", 0, 0, 0);

    // Zero start
    drive(1'b1, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
    pin("zero_e0", 0, 0, 1);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("zero_e1", 0, 0, 0);

    // 1023, five steps, then abort
    drive(1'b1, 1023, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    pin("max_e0", 1023, 1, 0);
    for (int i = 0; i < 5; i++) drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("max_e5", 1018, 1, 0);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    pin("max_abort", 1018, 0, 0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("max_idle", 1018, 0, 0);

    // load and start together: load wins
    drive(1'b1, 5, 1'b1, 1'b0, 1'b0);
    pin("ldst", 5, 0, 0);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    pin("ldst_idle", 5, 0, 0);

    // abort beats step
    drive(1'b1, 10, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b1);
    pin("abstep", 10, 0, 0);

    // load ignored in RUN
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    pin("ldrun_e0", 10, 1, 0);
    drive(1'b1, 7, 1'b0, 1'b1, 1'b0);
    pin("ldrun_e1", 9, 1, 0);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    pin("ldrun_abort", 9, 0, 0);
`endif

    // Asynchronous reset mid-RUN at count 36
    drive(1'b1, 40, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    pin("pre_reset", 36, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    pin("async_reset", 0, 0, 0);
    @(negedge clk);
    pin("reset_hold", 0, 0, 0);
    #2 rst_n = 1'b1;
    bus.step = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
